// File: rtl/keypad_answer_scanner_pkg.sv
// Shared quiz definitions for the answer keypads and the scoring logic.
// Holds the key geometry, the scanner FSM state type and the nine one-hot
// answer codes that both keypads and the scorer compare against.
package keypad_answer_scanner_pkg;

  localparam int KEY_W    = 9;
  localparam int KEY_ROWS = 3;
  localparam int KEY_COLS = 3;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESSED = 1'b1
  } kp_state_t;

  // Answer codes: bit index = row*3 + col.
  localparam logic [KEY_W-1:0] ANS_1 = 9'b000000001;
  localparam logic [KEY_W-1:0] ANS_2 = 9'b000000010;
  localparam logic [KEY_W-1:0] ANS_3 = 9'b000000100;
  localparam logic [KEY_W-1:0] ANS_4 = 9'b000001000;
  localparam logic [KEY_W-1:0] ANS_5 = 9'b000010000;
  localparam logic [KEY_W-1:0] ANS_6 = 9'b000100000;
  localparam logic [KEY_W-1:0] ANS_7 = 9'b001000000;
  localparam logic [KEY_W-1:0] ANS_8 = 9'b010000000;
  localparam logic [KEY_W-1:0] ANS_9 = 9'b100000000;

  // True when exactly one bit of v is set.
  function automatic logic is_one_hot(input logic [KEY_W-1:0] v);
    return (v != '0) && ((v & (v - 9'd1)) == '0);
  endfunction

endpackage

// File: rtl/keypad_answer_scanner_sync.sv
// keypad_sync: two-flop synchronizer for the asynchronous keypad columns.
// Ports:
//   clk   - clock
//   rst_n - asynchronous active-low reset; output resets to all ones (keys open)
//   d     - asynchronous input bus
//   q     - synchronized output bus, two cycles behind d
module keypad_sync #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/keypad_answer_scanner.sv
// keypad_answer_scanner: scans a 3x3 active-low keypad, debounces complete
// scans and reports a single accepted key as a one-hot answer code.
// Ports:
//   clk        - clock
//   rst_n      - asynchronous active-low reset
//   enable     - scanning enabled; low clears the scanner and its outputs
//   row_drive  - one-cold row strobe (bit r low drives row r)
//   col_sense  - asynchronous pulled-up column inputs (low = key closed)
//   key_onehot - accepted key, bit = row*3 + col; zero when none accepted
//   key_valid  - one-cycle pulse when a new key is accepted
//   key_held   - high while the accepted key has not been released
module keypad_answer_scanner
  import keypad_answer_scanner_pkg::*;
#(
  parameter int SCAN_DIV       = 4,
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  output logic [KEY_ROWS-1:0] row_drive,
  input  logic [KEY_COLS-1:0] col_sense,
  output logic [KEY_W-1:0]    key_onehot,
  output logic                key_valid,
  output logic                key_held
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int RUN_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(DEBOUNCE_SCANS);
  localparam logic [1:0]       ROW_LAST = 2'(KEY_ROWS - 1);

  logic [KEY_COLS-1:0] col_sync;
  logic [KEY_COLS-1:0] sense;

  logic [DIV_W-1:0]    div_q, div_d;
  logic [1:0]          row_q, row_d;
  logic [KEY_W-1:0]    snap_q, snap_d;
  logic [KEY_W-1:0]    prev_snap_q, prev_snap_d;
  logic [RUN_W-1:0]    run_q, run_d;
  kp_state_t           state_q, state_d;
  logic [KEY_W-1:0]    key_onehot_q, key_onehot_d;
  logic                key_valid_q, key_valid_d;
  logic                key_held_q, key_held_d;
  logic [KEY_ROWS-1:0] row_drive_q, row_drive_d;

  logic                sample;
  logic                scan_done;
  logic                stable;
  logic [KEY_W-1:0]    snap_full;
  logic [RUN_W-1:0]    run_next;

  keypad_sync #(.W(KEY_COLS)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (col_sense),
    .q     (col_sync)
  );

  assign sense = ~col_sync;

  always_comb begin
    div_d        = div_q;
    row_d        = row_q;
    snap_d       = snap_q;
    prev_snap_d  = prev_snap_q;
    run_d        = run_q;
    state_d      = state_q;
    key_onehot_d = key_onehot_q;
    key_held_d   = key_held_q;
    key_valid_d  = 1'b0;
    row_drive_d  = '1;
    sample       = 1'b0;
    scan_done    = 1'b0;
    stable       = 1'b0;
    snap_full    = snap_q;
    run_next     = run_q;

    if (!enable) begin
      div_d        = '0;
      row_d        = '0;
      snap_d       = '0;
      prev_snap_d  = '0;
      run_d        = '0;
      state_d      = IDLE;
      key_onehot_d = '0;
      key_held_d   = 1'b0;
    end else begin
      sample = (div_q == DIV_LAST);
      if (sample) begin
        div_d = '0;
        row_d = (row_q == ROW_LAST) ? 2'd0 : row_q + 2'd1;
        // Drop this row's columns into the snapshot; snap_full is the
        // snapshot including the current sample, so the last row of a scan
        // is visible to the debounce logic in the same cycle.
        case (row_q)
          2'd0:    snap_full[2:0] = sense;
          2'd1:    snap_full[5:3] = sense;
          default: snap_full[8:6] = sense;
        endcase
        snap_d    = snap_full;
        scan_done = (row_q == ROW_LAST);
      end else begin
        div_d = div_q + DIV_W'(1);
      end

      if (scan_done) begin
        if (snap_full == prev_snap_q) begin
          run_next = (run_q == RUN_MAX) ? RUN_MAX : run_q + RUN_W'(1);
        end else begin
          run_next = RUN_W'(1);
        end
        run_d       = run_next;
        prev_snap_d = snap_full;
        stable      = (run_next == RUN_MAX);
      end

      if (stable) begin
        case (state_q)
          IDLE: begin
            // Zero and multi-key snapshots never produce an answer.
            if (is_one_hot(snap_full)) begin
              key_onehot_d = snap_full;
              key_valid_d  = 1'b1;
              key_held_d   = 1'b1;
              state_d      = PRESSED;
            end
          end
          PRESSED: begin
            // Only a full release re-arms; extra or rolled keys are ignored.
            if (snap_full == '0) begin
              key_onehot_d = '0;
              key_held_d   = 1'b0;
              state_d      = IDLE;
            end
          end
          default: state_d = IDLE;
        endcase
      end

      // Registered strobe follows the row the counters move to.
      row_drive_d = ~(3'b001 << row_d);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q        <= '0;
      row_q        <= '0;
      snap_q       <= '0;
      prev_snap_q  <= '0;
      run_q        <= '0;
      state_q      <= IDLE;
      key_onehot_q <= '0;
      key_valid_q  <= 1'b0;
      key_held_q   <= 1'b0;
      row_drive_q  <= '1;
    end else begin
      div_q        <= div_d;
      row_q        <= row_d;
      snap_q       <= snap_d;
      prev_snap_q  <= prev_snap_d;
      run_q        <= run_d;
      state_q      <= state_d;
      key_onehot_q <= key_onehot_d;
      key_valid_q  <= key_valid_d;
      key_held_q   <= key_held_d;
      row_drive_q  <= row_drive_d;
    end
  end

  assign row_drive  = row_drive_q;
  assign key_onehot = key_onehot_q;
  assign key_valid  = key_valid_q;
  assign key_held   = key_held_q;

endmodule

// File: tb/tb_keypad_answer_scanner.sv
module tb_keypad_answer_scanner;
  import keypad_answer_scanner_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic [2:0] row_drive;
  logic [2:0] col_sense;
  logic [8:0] key_onehot;
  logic       key_valid;
  logic       key_held;

  logic [8:0] pressed = '0;   // physical key state, bit = row*3 + col

  int pass_cnt = 0;
  int total_cnt = 0;
  int pulses = 0;

  keypad_answer_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .row_drive  (row_drive),
    .col_sense  (col_sense),
    .key_onehot (key_onehot),
    .key_valid  (key_valid),
    .key_held   (key_held)
  );

  always #5 clk = ~clk;

  // Keypad matrix: a closed key pulls its column low while its row is driven.
  always_comb begin
    col_sense = 3'b111;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        if (pressed[r*3+c] && !row_drive[r]) col_sense[c] = 1'b0;
  end

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp_v);
    total_cnt++;
    if (act === exp_v) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp_v, $time);
  endtask

  // ---------------- behavioural model ----------------
  // Time is counted in enabled cycles t; a scan spans 12 cycles and row r is
  // read at t%12 == 4r+3, seeing the key state from two cycles earlier.
  // A key is accepted when the last three scans since enable are identical.
  int         t;
  logic [8:0] ph1, ph2, msnap;
  logic [8:0] scans[$];
  logic [8:0] exp_onehot;
  logic       exp_valid, exp_held;
  logic [2:0] exp_row_drive;
  logic [2:0] one3 = 3'b001;

  task automatic model_reset();
    t = 0;
    scans.delete();
    msnap = '0;
    exp_onehot = '0;
    exp_valid = 1'b0;
    exp_held = 1'b0;
    exp_row_drive = 3'b111;
  endtask

  task automatic model_step();
    logic [8:0] cur;
    logic       stab;
    int         ph;
    cur = pressed;
    exp_valid = 1'b0;
    if (!enable) begin
      t = 0;
      scans.delete();
      exp_onehot = '0;
      exp_held = 1'b0;
      exp_row_drive = 3'b111;
    end else begin
      ph = t % 12;
      if (ph % 4 == 3) msnap[(ph/4)*3 +: 3] = ph2[(ph/4)*3 +: 3];
      if (ph == 11) begin
        scans.push_back(msnap);
        if (scans.size() > 3) void'(scans.pop_front());
        stab = (scans.size() == 3) && (scans[0] == scans[1]) && (scans[1] == scans[2]);
        if (stab && !exp_held && $countones(msnap) == 1) begin
          exp_onehot = msnap;
          exp_valid = 1'b1;
          exp_held = 1'b1;
        end else if (stab && exp_held && msnap == 9'd0) begin
          exp_onehot = '0;
          exp_held = 1'b0;
        end
      end
      t++;
      exp_row_drive = ~(one3 << ((t % 12) / 4));
    end
    ph2 = ph1;
    ph1 = cur;
  endtask

  initial begin
    ph1 = '0;
    ph2 = '0;
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // Per-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      check("cyc_row_drive", {6'd0, row_drive}, {6'd0, exp_row_drive});
      check("cyc_key_onehot", key_onehot, exp_onehot);
      check("cyc_key_valid", {8'd0, key_valid}, {8'd0, exp_valid});
      check("cyc_key_held", {8'd0, key_held}, {8'd0, exp_held});
    end
  end

  // Pulse counter, sampled before the DUT updates on each edge.
  initial begin
    forever begin
      @(posedge clk);
      if (key_valid === 1'b1) pulses++;
    end
  end

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  int base;

  initial begin
    enable = 1'b1;
    wait_n(3);
    check("reset_row_drive", {6'd0, row_drive}, 9'b000000111);
    check("reset_onehot", key_onehot, 9'd0);
    check("reset_held", {8'd0, key_held}, 9'd0);
    rst_n = 1'b1;                                  // N_0, t = 0

    // Idle scanning pattern
    wait_n(13); check("idle_row0", {6'd0, row_drive}, 9'b000000110);   // N_13
    wait_n(4);  check("idle_row1", {6'd0, row_drive}, 9'b000000101);   // N_17
    wait_n(4);  check("idle_row2", {6'd0, row_drive}, 9'b000000011);   // N_21
    wait_n(3);  check("idle_row0_again", {6'd0, row_drive}, 9'b000000110); // N_24
    wait_n(36); check("idle_no_pulse", 9'(pulses), 9'd0);               // N_60

    // Clean press of row 1 col 2
    base = pulses;
    pressed = ANS_6;
    wait_n(35); check("press_before_accept", 9'(pulses - base), 9'd0); // N_95
    wait_n(1);
    check("press_valid", {8'd0, key_valid}, 9'd1);                      // N_96
    check("press_onehot", key_onehot, 9'b000100000);
    check("press_held", {8'd0, key_held}, 9'd1);
    wait_n(1);  check("press_valid_one_cycle", {8'd0, key_valid}, 9'd0); // N_97
    wait_n(11); pressed = '0;                                            // N_108
    wait_n(35); check("release_still_held", {8'd0, key_held}, 9'd1);    // N_143
    wait_n(1);
    check("release_held", {8'd0, key_held}, 9'd0);                      // N_144
    check("release_onehot", key_onehot, 9'd0);
    check("press_single_pulse", 9'(pulses - base), 9'd1);

    // Bounce on key 0 for six scans, then hold
    base = pulses;
    for (int s = 0; s < 6; s++) begin
      pressed = (s % 2 == 0) ? ANS_1 : 9'd0;
      wait_n(12);
    end
    check("bounce_no_pulse", 9'(pulses - base), 9'd0);                 // N_216
    pressed = ANS_1;
    wait_n(36);
    check("bounce_onehot", key_onehot, 9'b000000001);                   // N_252
    wait_n(1);
    check("bounce_one_pulse", 9'(pulses - base), 9'd1);
    pressed = '0;                                                        // N_253
    wait_n(47);                                                          // N_300

    // Two keys together: ignored
    base = pulses;
    pressed = ANS_1 | ANS_5;
    wait_n(60);
    check("multi_no_pulse", 9'(pulses - base), 9'd0);
    check("multi_not_held", {8'd0, key_held}, 9'd0);
    pressed = '0;
    wait_n(36);                                                          // N_396

    // Roll: key 8 accepted, add key 3, drop key 8
    base = pulses;
    pressed = ANS_9;
    wait_n(37);
    check("roll_onehot", key_onehot, 9'b100000000);
    pressed = ANS_9 | ANS_4;
    wait_n(47);
    pressed = ANS_4;
    wait_n(48);
    check("roll_onehot_kept", key_onehot, 9'b100000000);
    check("roll_single_pulse", 9'(pulses - base), 9'd1);
    pressed = '0;
    wait_n(48);
    check("roll_released", {8'd0, key_held}, 9'd0);

    // Enable drop while pressed
    pressed = ANS_2;
    wait_n(41);
    check("en_held_before_drop", {8'd0, key_held}, 9'd1);
    enable = 1'b0;
    wait_n(1);
    check("en_drop_row_drive", {6'd0, row_drive}, 9'b000000111);
    check("en_drop_onehot", key_onehot, 9'd0);
    check("en_drop_held", {8'd0, key_held}, 9'd0);
    wait_n(9);
    base = pulses;
    enable = 1'b1;                                                       // t = 0
    wait_n(36);
    check("reen_valid", {8'd0, key_valid}, 9'd1);                       // t = 36
    check("reen_onehot", key_onehot, 9'b000000010);
    wait_n(12);
    pressed = '0;                                                        // t = 48
    wait_n(36);
    check("reen_one_pulse", 9'(pulses - base), 9'd1);

    // Enable falls in the accepting scan_done cycle
    base = pulses;
    pressed = ANS_3;                                                     // t = 84
    wait_n(35);                                                          // t = 119
    enable = 1'b0;
    wait_n(2);
    check("en_wins_no_pulse", 9'(pulses - base), 9'd0);
    enable = 1'b1;                                                       // t = 0
    wait_n(36);
    check("en_after_onehot", key_onehot, 9'b000000100);

    // Asynchronous reset while held and mid-debounce of the release
    pressed = '0;
    wait_n(18);
    check("areset_pre_held", {8'd0, key_held}, 9'd1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("areset_row_drive", {6'd0, row_drive}, 9'b000000111);
    check("areset_onehot", key_onehot, 9'd0);
    check("areset_held", {8'd0, key_held}, 9'd0);
    check("areset_valid", {8'd0, key_valid}, 9'd0);
    base = pulses;
    @(negedge clk);
    rst_n = 1'b1;
    wait_n(30);
    check("post_reset_no_pulse", 9'(pulses - base), 9'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
